avmm_pio_pulse_out: RTL and testbench

// - Parametrised Avalon-MM output PIO: WIDTH-bit output register with atomic SET/CLEAR access and a

---
 rtl/avmm_pio_pkg.sv | 16 +
 rtl/pio_pulse_timer.sv | 65 ++++++
 rtl/avmm_pio_pulse_out.sv | 95 +++++++++
 tb/tb_avmm_pio_pulse_out.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_pio_pkg.sv
// Shared address map and pulse-engine state encoding for the Avalon-MM pulse PIO.
package avmm_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse engine: holds the inversion mask and counts the pulse down, one cycle per clk.
module pio_pulse_timer
    import avmm_pio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [WIDTH-1:0] bits_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic [WIDTH-1:0] mask_o
);

    pulse_state_t     state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] reload;

    // A zero length still produces a one-cycle pulse.
    assign reload = (len_i == '0) ? CNT_W'(1) : len_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        state_q <= PULSE;
                        mask_q  <= bits_i;
                        count_q <= reload;
                    end
                end
                PULSE: begin
                    if (load_i) begin
                        mask_q  <= mask_q | bits_i;
                        count_q <= reload;
                    end else if (count_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        mask_q  <= '0;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mask_q  <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign busy_o      = (state_q == PULSE);
    assign remaining_o = count_q;
    assign mask_o      = mask_q;

endmodule

// File: rtl/avmm_pio_pulse_out.sv
// Avalon-MM output PIO with atomic SET/CLEAR and a self-timed bit-inversion pulse engine.
module avmm_pio_pulse_out
    import avmm_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DEF_LEN     = CNT_W'(100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    logic             wr;
    logic [WIDTH-1:0] wd_data;
    logic [CNT_W-1:0] wd_len;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             pulse_load;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      rem32;
    logic             unused_bits;

    assign wr      = chipselect & ~write_n;
    assign wd_data = writedata[WIDTH-1:0];
    assign wd_len  = writedata[CNT_W-1:0];

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                ADDR_DATA:      data_d = wd_data;
                ADDR_SET:       data_d = data_q | wd_data;
                ADDR_CLEAR:     data_d = data_q & ~wd_data;
                ADDR_PULSE_LEN: len_d  = wd_len;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            len_q  <= DEF_LEN;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    // An all-zero PULSE write must not start or extend a pulse.
    assign pulse_load = wr && (address == ADDR_PULSE) && (wd_data != '0);

    pio_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (pulse_load),
        .len_i       (len_q),
        .bits_i      (wd_data),
        .busy_o      (pulse_busy),
        .remaining_o (remaining),
        .mask_o      (mask)
    );

    assign out_port = data_q ^ mask;

    // STATUS carries only the low 16 bits of the count in its upper half.
    assign rem32 = 32'(remaining);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_q);
            ADDR_PULSE_LEN:                  readdata = 32'(len_q);
            ADDR_PULSE:                      readdata = 32'(mask);
            ADDR_STATUS:                     readdata = {rem32[15:0], 15'd0, pulse_busy};
            default:                         readdata = '0;
        endcase
    end

    assign unused_bits = ^{writedata, rem32[31:16]};

endmodule

// File: tb/tb_avmm_pio_pulse_out.sv
// Directed and randomized bench for avmm_pio_pulse_out against a cycle-indexed pulse model.
module tb_avmm_pio_pulse_out;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 16;
    localparam logic [7:0] RV    = 8'hA5;
    localparam logic [15:0] DL   = 16'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;

    always #5 clk = ~clk;

    avmm_pio_pulse_out #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_W       (CNT_W),
        .DEF_LEN     (DL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: the pulse is described by the cycle index at which it ends.
    int          cyc = 0;
    logic [7:0]  m_data = 8'h00;
    logic [15:0] m_len = 16'd0;
    logic [7:0]  m_mask = 8'h00;
    int          m_end = 0;

    function automatic logic m_busy();
        return cyc < m_end;
    endfunction

    function automatic logic [7:0] m_eff_mask();
        return m_busy() ? m_mask : 8'h00;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [15:0] rem;
        rem = m_busy() ? 16'(m_end - cyc) : 16'd0;
        case (a)
            3'd0, 3'd1, 3'd2: return {24'd0, m_data};
            3'd3:             return {16'd0, m_len};
            3'd4:             return {24'd0, m_eff_mask()};
            3'd5:             return {rem, 15'd0, m_busy()};
            default:          return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_out"}, {24'd0, out_port}, {24'd0, m_data ^ m_eff_mask()});
        check({tag, "_busy"}, {31'd0, pulse_busy}, {31'd0, m_busy()});
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        v = readdata;
    endtask

    task automatic check_read(input string tag, input logic [2:0] a);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, m_read(a));
    endtask

    task automatic bus(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd, input string tag);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        if (rst) begin
            m_data = RV;
            m_len  = DL;
            m_mask = 8'h00;
            m_end  = 0;
        end else if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_data = m_data | wd[7:0];
                3'd2: m_data = m_data & ~wd[7:0];
                3'd3: m_len  = wd[15:0];
                3'd4: if (wd[7:0] != 8'h00) begin
                    m_mask = m_busy() ? (m_mask | wd[7:0]) : wd[7:0];
                    m_end  = cyc + 1 + ((m_len == 16'd0) ? 1 : int'(m_len));
                end
                default: ;
            endcase
        end
        cyc++;
        #1;
        reset = 1'b0;
        check_outs(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        bus(1'b0, 1'b1, 1'b0, a, wd, "wr");
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, "idle");
    endtask

    task automatic rst_cycle();
        bus(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, "rst");
    endtask

    initial begin
        logic [31:0] v;

        // Reset values
        rst_cycle();
        rst_cycle();
        check("rst_out", {24'd0, out_port}, 32'h0000_00A5);
        rd(3'd0, v); check("rst_data", v, 32'h0000_00A5);
        rd(3'd5, v); check("rst_status", v, 32'd0);
        rd(3'd3, v); check("rst_len", v, 32'd100);

        // SET / CLEAR
        wr(3'd0, 32'h0F);
        wr(3'd1, 32'h30);
        wr(3'd2, 32'h03);
        idle();
        check("setclr_out", {24'd0, out_port}, 32'h3C);
        for (int a = 0; a < 3; a++) begin
            rd(3'(a), v);
            check("setclr_rd", v, 32'h3C);
        end

        // Exact pulse width, length 5
        wr(3'd3, 32'd5);
        wr(3'd0, 32'hFF);
        wr(3'd4, 32'h01);
        for (int i = 0; i < 5; i++) begin
            check("pw5_out", {24'd0, out_port}, 32'hFE);
            check("pw5_busy", {31'd0, pulse_busy}, 32'd1);
            idle();
        end
        check("pw5_end_out", {24'd0, out_port}, 32'hFF);
        check("pw5_end_busy", {31'd0, pulse_busy}, 32'd0);

        // Length 0 behaves as 1
        wr(3'd3, 32'd0);
        wr(3'd4, 32'h01);
        check("pw0_out", {24'd0, out_port}, 32'hFE);
        check("pw0_busy", {31'd0, pulse_busy}, 32'd1);
        idle();
        check("pw0_end_out", {24'd0, out_port}, 32'hFF);
        check("pw0_end_busy", {31'd0, pulse_busy}, 32'd0);

        // Retrigger extends all bits
        wr(3'd3, 32'd10);
        wr(3'd4, 32'h01);
        idle(); idle(); idle();
        wr(3'd4, 32'h02);
        for (int k = 10; k >= 1; k--) begin
            check("retrig_out", {24'd0, out_port}, 32'hFC);
            rd(3'd5, v);
            check("retrig_status", v, (32'(k) << 16) | 32'd1);
            idle();
        end
        check("retrig_end_out", {24'd0, out_port}, 32'hFF);
        rd(3'd5, v); check("retrig_end_status", v, 32'd0);

        // DATA write during a pulse
        wr(3'd4, 32'h01);
        idle(); idle();
        wr(3'd0, 32'h80);
        for (int i = 0; i < 7; i++) begin
            check("mid_out", {24'd0, out_port}, 32'h81);
            idle();
        end
        check("mid_end_out", {24'd0, out_port}, 32'h80);

        // Reset aborts a pulse
        wr(3'd4, 32'h01);
        idle();
        rst_cycle();
        check("rstpulse_out", {24'd0, out_port}, 32'hA5);
        check("rstpulse_busy", {31'd0, pulse_busy}, 32'd0);

        // Ignored accesses
        wr(3'd0, 32'h5A);
        wr(3'd3, 32'd7);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        bus(1'b0, 1'b0, 1'b0, 3'd0, 32'hFF, "nocs");
        bus(1'b0, 1'b0, 1'b0, 3'd4, 32'hFF, "nocs_pulse");
        wr(3'd4, 32'hFFFF_FF00);
        check("ign_out", {24'd0, out_port}, 32'h5A);
        check("ign_busy", {31'd0, pulse_busy}, 32'd0);
        rd(3'd0, v); check("ign_data", v, 32'h5A);
        rd(3'd3, v); check("ign_len", v, 32'd7);
        rd(3'd4, v); check("ign_mask", v, 32'd0);
        rd(3'd6, v); check("rd6", v, 32'd0);
        rd(3'd7, v); check("rd7", v, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            logic        cs, wn, rs;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 7) != 0);
            wn = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 79) == 0);
            wd = $urandom;
            if (a == 3'd3) wd = {$urandom_range(0, 65535), 16'd0} | 32'($urandom_range(0, 12));
            if (a == 3'd4 && $urandom_range(0, 5) == 0) wd = wd & 32'hFFFF_FF00;
            bus(rs, cs, wn, a, wd, "rnd");
            check_read("rnd_rd", 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
